addr_trace_gen: RTL and testbench

Address-trace generator that drives the 32-bit `address` input of the set-associative cache models. It issues one word-aligned address per clock from a programmed pattern: sequential, strided, looping or pseudo-random. It provides a start/busy/done handshake so a bench or top level can run a hit/miss experiment of exact length. It is the initiator side of the cache's per-cycle address interface.

---
 rtl/addr_trace_gen.sv | 138 +++++++++++++
 tb/tb_addr_trace_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/addr_trace_gen.sv
// Address-trace generator: issues one word-aligned address per cycle from a
// sequential, strided, looping or LFSR pattern under a start/busy/done handshake.
module addr_trace_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [LEN_W-1:0]  span_i,
  input  logic [LEN_W-1:0]  length_i,
  input  logic              hold_i,
  output logic [ADDR_W-1:0] address_o,
  output logic              addr_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  issued_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [ADDR_W-1:0] LfsrMask = ADDR_W'(32'h8020_0003);

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [LEN_W-1:0]  span_q, span_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] gen_q, gen_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [LEN_W-1:0]  issued_q, issued_d;

  logic              issue;
  logic [ADDR_W-1:0] elem;
  logic [LEN_W-1:0]  span_eff;

  function automatic logic [ADDR_W-1:0] lfsr_next(input logic [ADDR_W-1:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LfsrMask) : (s >> 1);
  endfunction

  assign issue    = (state_q == StRun) && !hold_i;
  assign elem     = {gen_q[ADDR_W-1:2], 2'b00};
  assign span_eff = (span_q == '0) ? LEN_W'(1) : span_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    stride_d = stride_q;
    span_d   = span_q;
    len_d    = len_q;
    gen_d    = gen_q;
    idx_d    = idx_q;
    last_d   = last_q;
    issued_d = issued_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d   = mode_i;
          base_d   = base_i;
          stride_d = stride_i;
          span_d   = span_i;
          len_d    = length_i;
          issued_d = '0;
          idx_d    = '0;
          // A zero seed would lock the LFSR, so it is replaced by 1.
          if (mode_i == 2'd3 && base_i == '0) gen_d = ADDR_W'(1);
          else                                gen_d = base_i;
          state_d  = (length_i == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (!hold_i) begin
          last_d   = elem;
          issued_d = issued_q + LEN_W'(1);
          case (mode_q)
            2'd0: gen_d = gen_q + ADDR_W'(4);
            2'd1: gen_d = gen_q + stride_q;
            2'd2: begin
              if (idx_q + LEN_W'(1) >= span_eff) begin
                idx_d = '0;
                gen_d = base_q;
              end else begin
                idx_d = idx_q + LEN_W'(1);
                gen_d = gen_q + ADDR_W'(4);
              end
            end
            default: gen_d = lfsr_next(gen_q);
          endcase
          if (issued_q + LEN_W'(1) == len_q) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      mode_q   <= '0;
      base_q   <= '0;
      stride_q <= '0;
      span_q   <= '0;
      len_q    <= '0;
      gen_q    <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      stride_q <= stride_d;
      span_q   <= span_d;
      len_q    <= len_d;
      gen_q    <= gen_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      issued_q <= issued_d;
    end
  end

  // Held or idle cycles present the most recently issued element.
  assign address_o    = issue ? elem : last_q;
  assign addr_valid_o = issue;
  assign busy_o       = (state_q == StRun);
  assign done_o       = (state_q == StDone);
  assign issued_o     = issued_q;

endmodule

// File: tb/tb_addr_trace_gen.sv
// Self-checking bench for addr_trace_gen: per-cycle model comparison plus
// directed runs with literal expected traces.
module tb_addr_trace_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] base;
  logic [31:0] stride;
  logic [15:0] span;
  logic [15:0] length;
  logic        hold;
  logic [31:0] address;
  logic        addr_valid;
  logic        busy;
  logic        done;
  logic [15:0] issued;

  addr_trace_gen #(.ADDR_W(32), .LEN_W(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .mode_i      (mode),
    .base_i      (base),
    .stride_i    (stride),
    .span_i      (span),
    .length_i    (length),
    .hold_i      (hold),
    .address_o   (address),
    .addr_valid_o(addr_valid),
    .busy_o      (busy),
    .done_o      (done),
    .issued_o    (issued)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] got[$];
  logic [31:0] want[$];
  int done_k;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
    end
  endfunction

  // Element i of a run, straight from the pattern definitions.
  function automatic logic [31:0] model_elem(input logic [1:0] m, input logic [31:0] b,
                                             input logic [31:0] s, input logic [15:0] sp,
                                             input int i);
    logic [31:0] x;
    int spn;
    case (m)
      2'd0: x = b + 32'(4 * i);
      2'd1: x = b + s * 32'(i);
      2'd2: begin
        spn = (sp == 16'd0) ? 1 : int'(sp);
        x = b + 32'(4 * (i % spn));
      end
      default: begin
        x = (b == 32'd0) ? 32'd1 : b;
        for (int k = 0; k < i; k++) x = x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
      end
    endcase
    return {x[31:2], 2'b00};
  endfunction

  // Model: 0 idle, 1 run, 2 done.
  int          m_phase = 0;
  int          m_i = 0;
  int          m_len = 0;
  logic [1:0]  m_mode = '0;
  logic [31:0] m_base = '0;
  logic [31:0] m_stride = '0;
  logic [15:0] m_span = '0;
  logic [31:0] m_last = '0;
  logic [15:0] m_issued = '0;

  always @(negedge clk) begin
    logic        ev;
    logic [31:0] ea;
    if (!rst_n) begin
      m_phase = 0; m_i = 0; m_last = '0; m_issued = '0;
    end
    ev = (m_phase == 1) && !hold;
    ea = ev ? model_elem(m_mode, m_base, m_stride, m_span, m_i) : m_last;
    check("address", address, ea);
    check("addr_valid", 32'(addr_valid), 32'(ev));
    check("busy", 32'(busy), 32'(m_phase == 1));
    check("done", 32'(done), 32'(m_phase == 2));
    check("issued", 32'(issued), 32'(m_issued));
    if (addr_valid) got.push_back(address);
    if (rst_n) begin
      case (m_phase)
        0: if (start) begin
          m_mode = mode; m_base = base; m_stride = stride; m_span = span;
          m_len = int'(length); m_i = 0; m_issued = '0;
          m_phase = (length == 16'd0) ? 2 : 1;
        end
        1: if (!hold) begin
          m_last = ea;
          m_i++;
          m_issued++;
          if (m_i == m_len) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic run(input logic [1:0] m, input logic [31:0] b, input logic [31:0] s,
                     input logic [15:0] sp, input logic [15:0] ln,
                     input int hold_at, input int restart_at, input int rst_at);
    @(posedge clk); #1;
    mode = m; base = b; stride = s; span = sp; length = ln; start = 1'b1;
    got.delete();
    done_k = -1;
    @(posedge clk); #1;
    // Scramble configuration; the run must use the latched copy.
    start = 1'b0; mode = m ^ 2'b01; base = 32'hdead_beef; stride = 32'h4;
    span = 16'd1; length = 16'hffff;
    for (int k = 1; k < 200; k++) begin
      hold  = (k == hold_at);
      start = (k == restart_at);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_address", address, 32'h0);
        check("rst_issued", 32'(issued), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        break;
      end
      @(negedge clk);
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    start = 1'b0;
    if (done_k < 0 && rst_at < 0) check("timeout", 32'h0, 32'h1);
  endtask

  task automatic cmp_seq(input string nm);
    check({nm, "_count"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++) check(nm, got[i], want[i]);
    want.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = '0; base = '0; stride = '0;
    span = '0; length = '0; hold = 1'b0;
    #17 rst_n = 1'b1;

    run(2'd0, 32'hffff_fff8, 32'h0, 16'd0, 16'd3, -1, -1, -1);
    want = '{32'hffff_fff8, 32'hffff_fffc, 32'h0000_0000};
    cmp_seq("seq_wrap");
    check("seq_wrap_done_cycle", 32'(done_k), 32'd4);
    check("seq_wrap_issued", 32'(issued), 32'd3);

    run(2'd1, 32'h0, 32'h0004_0000, 16'd0, 16'd5, -1, -1, -1);
    want = '{32'h0, 32'h40000, 32'h80000, 32'hc0000, 32'h100000};
    cmp_seq("strided");

    run(2'd2, 32'h200, 32'h0, 16'd3, 16'd7, -1, -1, -1);
    want = '{32'h200, 32'h204, 32'h208, 32'h200, 32'h204, 32'h208, 32'h200};
    cmp_seq("loop_span3");

    run(2'd2, 32'h200, 32'h0, 16'd0, 16'd2, -1, -1, -1);
    want = '{32'h200, 32'h200};
    cmp_seq("loop_span0");

    run(2'd3, 32'h0, 32'h0, 16'd0, 16'd3, -1, -1, -1);
    want = '{32'h0000_0000, 32'h8020_0000, 32'hc030_0000};
    cmp_seq("lfsr_seed0");

    run(2'd3, 32'h13, 32'h0, 16'd0, 16'd1, -1, -1, -1);
    want = '{32'h10};
    cmp_seq("lfsr_seed13");

    run(2'd0, 32'h1000, 32'h0, 16'd0, 16'd4, 2, -1, -1);
    want = '{32'h1000, 32'h1004, 32'h1008, 32'h100c};
    cmp_seq("hold");
    check("hold_done_cycle", 32'(done_k), 32'd6);

    run(2'd0, 32'h2000, 32'h0, 16'd0, 16'd3, -1, 2, -1);
    want = '{32'h2000, 32'h2004, 32'h2008};
    cmp_seq("restart_busy");
    check("restart_busy_done_cycle", 32'(done_k), 32'd4);

    run(2'd0, 32'h4000, 32'h0, 16'd0, 16'd0, -1, -1, -1);
    cmp_seq("len0");
    check("len0_done_cycle", 32'(done_k), 32'd1);

    run(2'd0, 32'h5000, 32'h0, 16'd0, 16'd10, -1, -1, 2);
    want = '{32'h5000};
    cmp_seq("rst_midrun");

    run(2'd0, 32'h3000, 32'h0, 16'd0, 16'd2, -1, -1, -1);
    want = '{32'h3000, 32'h3004};
    cmp_seq("after_rst");
    check("after_rst_issued", 32'(issued), 32'd2);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
